// File: rtl/alu_operand_seq.sv
// Operand source for ALU bring-up: presents one (A,B) pair from a fixed table of
// corner cases or from two Galois LFSRs, selected by switches, step button or timer.
module alu_operand_seq #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [2:0]       sel,
  input  logic             step,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       idx,
  output logic             valid,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_STEP   = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_RANDOM = 2'b11
  } mode_e;

  localparam int                TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(DEPTH - 1);
  localparam logic [31:0]       LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0]       SEED_A    = 32'hACE1_2468;
  localparam logic [31:0]       SEED_B    = 32'h1357_9BDF;
  localparam logic [31:0]       E1_B      = 32'h0000_0607;
  localparam logic [31:0]       E7_A      = 32'h1234_5678;
  localparam logic [31:0]       E7_B      = 32'h1111_2222;
  localparam logic [WIDTH-1:0]  ONES      = '1;
  localparam logic [WIDTH-1:0]  MIN_V     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  MAX_V     = {1'b0, {(WIDTH-1){1'b1}}};

  function automatic logic [WIDTH-1:0] entry(input int i, input logic is_b);
    logic [WIDTH-1:0] v;
    case (i)
      0:       v = '0;
      1:       v = is_b ? E1_B[WIDTH-1:0] : WIDTH'(3);
      2:       v = MIN_V;
      3:       v = MAX_V;
      4:       v = ONES;
      5:       v = is_b ? ONES : MIN_V;
      6:       v = is_b ? MIN_V : ONES;
      default: v = is_b ? E7_B[WIDTH-1:0] : E7_A[WIDTH-1:0];
    endcase
    return v;
  endfunction

  function automatic logic [31:0] lfsr_shift(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  logic [WIDTH-1:0] tbl_a [8];
  logic [WIDTH-1:0] tbl_b [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_tbl
      assign tbl_a[gi] = entry(gi, 1'b0);
      assign tbl_b[gi] = entry(gi, 1'b1);
    end
  endgenerate

  logic [WIDTH-1:0]  a_reg, a_next;
  logic [WIDTH-1:0]  b_reg, b_next;
  logic [2:0]        idx_reg, idx_next;
  logic              valid_reg, valid_next;
  logic              wrap_reg, wrap_next;
  logic [TICK_W-1:0] tick_reg, tick_next;
  logic [31:0]       lfsr_a_reg, lfsr_a_next;
  logic [31:0]       lfsr_b_reg, lfsr_b_next;
  logic              step_d_reg;
  logic              run_reg;
  logic              sedge;
  logic              advance;

  assign sedge = step & ~step_d_reg;

  always_comb begin
    idx_next    = idx_reg;
    tick_next   = '0;
    lfsr_a_next = lfsr_a_reg;
    lfsr_b_next = lfsr_b_reg;
    advance     = 1'b0;
    case (mode_e'(mode))
      MODE_MANUAL: idx_next = (sel > IDX_LAST) ? IDX_LAST : sel;
      MODE_STEP:   advance = sedge;
      MODE_AUTO: begin
        advance   = (tick_reg == TICK_LAST);
        tick_next = advance ? '0 : tick_reg + TICK_W'(1);
      end
      default: begin
        if (sedge) begin
          lfsr_a_next = lfsr_shift(lfsr_a_reg);
          lfsr_b_next = lfsr_shift(lfsr_b_reg);
        end
      end
    endcase
    wrap_next = advance && (idx_reg == IDX_LAST);
    if (advance) begin
      idx_next = wrap_next ? 3'd0 : idx_reg + 3'd1;
    end
    // Table modes read the entry selected on this same edge, so A/B never lag idx.
    if (mode_e'(mode) == MODE_RANDOM) begin
      a_next = lfsr_a_next[WIDTH-1:0];
      b_next = lfsr_b_next[WIDTH-1:0];
    end else begin
      a_next = tbl_a[idx_next];
      b_next = tbl_b[idx_next];
    end
    valid_next = (a_next != a_reg) || (b_next != b_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      idx_reg    <= '0;
      valid_reg  <= 1'b0;
      wrap_reg   <= 1'b0;
      tick_reg   <= '0;
      lfsr_a_reg <= SEED_A;
      lfsr_b_reg <= SEED_B;
      step_d_reg <= 1'b0;
      run_reg    <= 1'b0;
    end else begin
      step_d_reg <= step;
      run_reg    <= 1'b1;
      // First edge after release only arms the block, so it cannot pulse valid/wrap.
      if (run_reg) begin
        a_reg      <= a_next;
        b_reg      <= b_next;
        idx_reg    <= idx_next;
        valid_reg  <= valid_next;
        wrap_reg   <= wrap_next;
        tick_reg   <= tick_next;
        lfsr_a_reg <= lfsr_a_next;
        lfsr_b_reg <= lfsr_b_next;
      end
    end
  end

  assign A     = a_reg;
  assign B     = b_reg;
  assign idx   = idx_reg;
  assign valid = valid_reg;
  assign wrap  = wrap_reg;

endmodule
